// File: rtl/act_requant_array_pkg.sv
// Shared definitions for the activation + requantisation array.
//   state_e      : FSM encoding (idle / running beats / result held)
//   ActRelu/Ident: cfg_mode encodings
//   beat_width() : width of a beat counter that never collapses to zero bits
package act_requant_array_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

  localparam logic ActRelu  = 1'b0;
  localparam logic ActIdent = 1'b1;

  function automatic int unsigned beat_width(input int unsigned beats);
    return (beats > 1) ? $clog2(beats) : 1;
  endfunction

endpackage

// File: rtl/act_requant_array_lane.sv
// One neuron of the requantisation datapath, purely combinational.
//   z     : signed IN_W-bit accumulator
//   mode  : ActRelu clamps negatives to zero, ActIdent passes through
//   rnd   : add half an LSB of the result before shifting
//   shift : right-shift amount, clamped to IN_W-1
//   y     : signed OUT_W-bit result
//   sat   : result was clamped to the output range
module act_requant_array_lane
  import act_requant_array_pkg::*;
#(
  parameter int unsigned IN_W  = 20,
  parameter int unsigned OUT_W = 8,
  parameter int unsigned SHW   = 5
) (
  input  logic [IN_W-1:0]  z,
  input  logic             mode,
  input  logic             rnd,
  input  logic [SHW-1:0]   shift,
  output logic [OUT_W-1:0] y,
  output logic             sat
);

  // One guard bit so the rounding add cannot overflow.
  localparam int unsigned XW = IN_W + 1;
  localparam logic [SHW-1:0] ShMax = SHW'(IN_W - 1);
  localparam logic signed [XW-1:0] OutMax = XW'((2 ** (OUT_W - 1)) - 1);
  localparam logic signed [XW-1:0] OutMin = ~OutMax;

  logic [SHW-1:0]        sh;
  logic signed [XW-1:0]  x;
  logic signed [XW-1:0]  r;
  logic signed [XW-1:0]  q;
  logic signed [XW-1:0]  lo;

  always_comb begin
    sh = (shift > ShMax) ? ShMax : shift;
    x  = (mode == ActRelu && z[IN_W-1]) ? '0 : {z[IN_W-1], z};
    r  = x;
    if (rnd && sh != '0) begin
      r = x + (XW'(1) << (sh - 1'b1));
    end
    q  = r >>> sh;
    // ReLU output is never negative, so its lower bound is zero; the ReLU
    // clamp itself produces zero without touching sat.
    lo = (mode == ActRelu) ? '0 : OutMin;

    y   = q[OUT_W-1:0];
    sat = 1'b0;
    if (q > OutMax) begin
      y   = OutMax[OUT_W-1:0];
      sat = 1'b1;
    end else if (q < lo) begin
      y   = lo[OUT_W-1:0];
      sat = 1'b1;
    end
  end

endmodule

// File: rtl/act_requant_array.sv
// Activation + requantisation stage between the accumulator bank and the next
// layer's input buffer. Accepts a packed vector of N_NEURONS signed
// accumulators, processes LANES neurons per cycle over BEATS=N_NEURONS/LANES
// cycles, and presents a packed OUT_W-bit vector with a saturation flag.
//   clk, rst_n         : clock, synchronous active-low reset
//   in_valid/in_ready  : input handshake (ready only when idle)
//   z_in_packed        : neuron j at [j*IN_W +: IN_W]
//   cfg_mode/round/shift : per-vector configuration, captured at accept
//   out_valid/out_ready: output handshake (valid only in DONE)
//   a_out_packed       : neuron j at [j*OUT_W +: OUT_W]
//   out_sat            : any neuron of the vector saturated
//   busy               : not idle
module act_requant_array
  import act_requant_array_pkg::*;
#(
  parameter int unsigned N_NEURONS = 32,
  parameter int unsigned LANES     = 8,
  parameter int unsigned IN_W      = 20,
  parameter int unsigned OUT_W     = 8,
  parameter int unsigned SHW       = 5
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [N_NEURONS*IN_W-1:0]  z_in_packed,
  input  logic                       cfg_mode,
  input  logic                       cfg_round,
  input  logic [SHW-1:0]             cfg_shift,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [N_NEURONS*OUT_W-1:0] a_out_packed,
  output logic                       out_sat,
  output logic                       busy
);

  localparam int unsigned BEATS    = N_NEURONS / LANES;
  localparam int unsigned BeatW    = beat_width(BEATS);
  localparam int unsigned SliceIn  = LANES * IN_W;
  localparam int unsigned SliceOut = LANES * OUT_W;
  localparam logic [BeatW-1:0] LastBeat = BeatW'(BEATS - 1);

  if (N_NEURONS % LANES != 0) begin : g_bad_lanes
    $error("act_requant_array: N_NEURONS must be a multiple of LANES");
  end

  state_e                     state_q, state_d;
  logic [BeatW-1:0]           beat_q, beat_d;
  logic [N_NEURONS*IN_W-1:0]  z_q;
  logic                       mode_q;
  logic                       round_q;
  logic [SHW-1:0]             shift_q;
  logic [N_NEURONS*OUT_W-1:0] out_q, out_d;
  logic                       sat_q, sat_d;

  logic                       accept;
  logic                       last_beat;
  logic [SliceIn-1:0]         slice_z;
  logic [SliceOut-1:0]        lane_y;
  logic [LANES-1:0]           lane_sat;

  assign accept    = in_valid && in_ready;
  assign last_beat = (beat_q == LastBeat);
  assign slice_z   = z_q[beat_q * SliceIn +: SliceIn];

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    act_requant_array_lane #(
      .IN_W  (IN_W),
      .OUT_W (OUT_W),
      .SHW   (SHW)
    ) u_lane (
      .z     (slice_z[i*IN_W +: IN_W]),
      .mode  (mode_q),
      .rnd   (round_q),
      .shift (shift_q),
      .y     (lane_y[i*OUT_W +: OUT_W]),
      .sat   (lane_sat[i])
    );
  end

  // FSM: state register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (in_valid)  state_d = StRun;
      StRun:   if (last_beat) state_d = StDone;
      StDone:  if (out_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // FSM: outputs
  always_comb begin
    in_ready  = (state_q == StIdle);
    out_valid = (state_q == StDone);
    busy      = (state_q != StIdle);
  end

  // Datapath next state: each RUN beat fills one LANES-wide slice of the result.
  always_comb begin
    beat_d = beat_q;
    out_d  = out_q;
    sat_d  = sat_q;
    if (accept) begin
      beat_d = '0;
      sat_d  = 1'b0;
    end else if (state_q == StRun) begin
      out_d[beat_q * SliceOut +: SliceOut] = lane_y;
      sat_d = sat_q | (|lane_sat);
      if (!last_beat) begin
        beat_d = beat_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      beat_q  <= '0;
      out_q   <= '0;
      sat_q   <= 1'b0;
      z_q     <= '0;
      mode_q  <= ActRelu;
      round_q <= 1'b0;
      shift_q <= '0;
    end else begin
      beat_q <= beat_d;
      out_q  <= out_d;
      sat_q  <= sat_d;
      if (accept) begin
        z_q     <= z_in_packed;
        mode_q  <= cfg_mode;
        round_q <= cfg_round;
        shift_q <= cfg_shift;
      end
    end
  end

  assign a_out_packed = out_q;
  assign out_sat      = sat_q;

endmodule

// File: tb/tb_act_requant_array.sv
module tb_act_requant_array;

  localparam int N  = 32;
  localparam int IW = 20;
  localparam int OW = 8;
  localparam int SW = 5;

  logic clk = 1'b0;
  logic rst_n;
  logic [N*IW-1:0] z_in_packed;
  logic cfg_mode, cfg_round;
  logic [SW-1:0] cfg_shift;

  logic in_valid, in_ready, out_valid, out_ready, out_sat, busy;
  logic [N*OW-1:0] a_out_packed;

  logic in_valid_w, in_ready_w, out_valid_w, out_ready_w, out_sat_w, busy_w;
  logic [N*OW-1:0] a_out_w;
  logic in_valid_n, in_ready_n, out_valid_n, out_ready_n, out_sat_n, busy_n;
  logic [N*OW-1:0] a_out_n;

  // sel picks which alternate-parameter instance the random tests drive.
  int   sel;
  logic alt_in_valid, alt_out_ready;
  logic alt_out_valid, alt_out_sat;
  logic [N*OW-1:0] alt_a_out;

  int n_checks;
  int n_fail;

  always #5 clk = ~clk;

  act_requant_array u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .z_in_packed(z_in_packed), .cfg_mode(cfg_mode), .cfg_round(cfg_round),
    .cfg_shift(cfg_shift), .out_valid(out_valid), .out_ready(out_ready),
    .a_out_packed(a_out_packed), .out_sat(out_sat), .busy(busy)
  );

  act_requant_array #(.LANES(32)) u_dut_w (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_w), .in_ready(in_ready_w),
    .z_in_packed(z_in_packed), .cfg_mode(cfg_mode), .cfg_round(cfg_round),
    .cfg_shift(cfg_shift), .out_valid(out_valid_w), .out_ready(out_ready_w),
    .a_out_packed(a_out_w), .out_sat(out_sat_w), .busy(busy_w)
  );

  act_requant_array #(.LANES(1)) u_dut_n (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_n), .in_ready(in_ready_n),
    .z_in_packed(z_in_packed), .cfg_mode(cfg_mode), .cfg_round(cfg_round),
    .cfg_shift(cfg_shift), .out_valid(out_valid_n), .out_ready(out_ready_n),
    .a_out_packed(a_out_n), .out_sat(out_sat_n), .busy(busy_n)
  );

  assign in_valid_w    = alt_in_valid && (sel == 0);
  assign in_valid_n    = alt_in_valid && (sel == 1);
  assign out_ready_w   = alt_out_ready && (sel == 0);
  assign out_ready_n   = alt_out_ready && (sel == 1);
  assign alt_out_valid = (sel == 0) ? out_valid_w : out_valid_n;
  assign alt_out_sat   = (sel == 0) ? out_sat_w : out_sat_n;
  assign alt_a_out     = (sel == 0) ? a_out_w : a_out_n;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Independent integer reference for one neuron.
  function automatic logic [7:0] ref_q(input int z, input bit mode, input bit rnd,
                                       input int shift, output bit sat);
    longint x;
    longint lo;
    int     sh;
    sh = (shift > IW - 1) ? IW - 1 : shift;
    x  = (!mode && z < 0) ? 0 : z;
    if (rnd && sh != 0) x = x + (longint'(1) << (sh - 1));
    x   = x >>> sh;
    lo  = mode ? -128 : 0;
    sat = 1'b0;
    if (x > 127) begin
      x = 127; sat = 1'b1;
    end else if (x < lo) begin
      x = lo; sat = 1'b1;
    end
    return x[7:0];
  endfunction

  function automatic logic [255:0] exp4(input logic [7:0] b0, input logic [7:0] b1,
                                        input logic [7:0] b2, input logic [7:0] b3);
    return {224'b0, b3, b2, b1, b0};
  endfunction

  task automatic set_z4(input int z0, input int z1, input int z2, input int z3);
    z_in_packed = '0;
    z_in_packed[0*IW +: IW] = z0[IW-1:0];
    z_in_packed[1*IW +: IW] = z1[IW-1:0];
    z_in_packed[2*IW +: IW] = z2[IW-1:0];
    z_in_packed[3*IW +: IW] = z3[IW-1:0];
  endtask

  task automatic set_cfg(input bit mode, input bit rnd, input int shift);
    cfg_mode  = mode;
    cfg_round = rnd;
    cfg_shift = shift[SW-1:0];
  endtask

  // Accept on the main DUT, then disturb inputs while it runs.
  task automatic send_main(input string tag);
    int lat;
    check({tag, "_in_ready"}, in_ready, 1);
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid    = 1'b0;
    z_in_packed = {20{$urandom}};
    cfg_mode    = ~cfg_mode;
    cfg_round   = ~cfg_round;
    cfg_shift   = cfg_shift + 5'd3;
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, "_latency"}, lat, 4);
  endtask

  task automatic retire_main(input string tag);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, "_ready_after"}, in_ready, 1);
  endtask

  task automatic rand_vec(input int which, input int exp_lat);
    logic [255:0]  exp;
    logic [IW-1:0] r20;
    bit            exp_sat;
    bit            s;
    int            zi;
    int            lat;
    sel = which;
    set_cfg(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(0, 31));
    exp     = '0;
    exp_sat = 1'b0;
    for (int j = 0; j < N; j++) begin
      r20 = IW'($urandom);
      if ($urandom_range(0, 1) == 1) r20 = IW'($signed(r20) >>> 8);
      zi = int'($signed(r20));
      z_in_packed[j*IW +: IW] = r20;
      exp[j*OW +: OW] = ref_q(zi, cfg_mode, cfg_round, int'(cfg_shift), s);
      exp_sat |= s;
    end
    alt_in_valid = 1'b1;
    @(posedge clk); #1;
    alt_in_valid = 1'b0;
    lat = 0;
    while (!alt_out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    check("rand_latency", lat, exp_lat);
    check("rand_data", alt_a_out, exp);
    check("rand_sat", alt_out_sat, exp_sat);
    alt_out_ready = 1'b1;
    @(posedge clk); #1;
    alt_out_ready = 1'b0;
  endtask

  initial begin
    int lat;
    n_checks = 0;
    n_fail   = 0;
    sel = 0;
    alt_in_valid  = 1'b0;
    alt_out_ready = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    z_in_packed = '0;
    set_cfg(1'b0, 1'b0, 8);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_a_out", a_out_packed, 0);
    check("rst_sat", out_sat, 0);
    check("rst_w_ready", in_ready_w, 1);
    check("rst_n_ready", in_ready_n, 1);

    // ReLU, no rounding
    set_z4(-5, 4660, 32767, 40000); set_cfg(1'b0, 1'b0, 8);
    send_main("t1a");
    check("t1a_data", a_out_packed, exp4(8'h00, 8'h12, 8'h7f, 8'h7f));
    check("t1a_sat", out_sat, 1);
    retire_main("t1a");
    set_z4(-5, 4660, 32767, 0); set_cfg(1'b0, 1'b0, 8);
    send_main("t1b");
    check("t1b_data", a_out_packed, exp4(8'h00, 8'h12, 8'h7f, 8'h00));
    check("t1b_sat", out_sat, 0);
    retire_main("t1b");

    // ReLU with rounding
    set_z4(383, 384, 127, 128); set_cfg(1'b0, 1'b1, 8);
    send_main("t2a");
    check("t2a_data", a_out_packed, exp4(8'd1, 8'd2, 8'd0, 8'd1));
    check("t2a_sat", out_sat, 0);
    retire_main("t2a");
    set_z4(100, 0, 0, 0); set_cfg(1'b0, 1'b1, 0);
    send_main("t2b");
    check("t2b_data", a_out_packed, exp4(8'd100, 8'd0, 8'd0, 8'd0));
    retire_main("t2b");

    // Identity
    set_z4(-300, -256, -40000, 32767); set_cfg(1'b1, 1'b0, 8);
    send_main("t3a");
    check("t3a_data", a_out_packed, exp4(8'hfe, 8'hff, 8'h80, 8'h7f));
    check("t3a_sat", out_sat, 1);
    retire_main("t3a");
    set_z4(-300, 0, 0, 0); set_cfg(1'b1, 1'b1, 8);
    send_main("t3b");
    check("t3b_data", a_out_packed, exp4(8'hff, 8'h00, 8'h00, 8'h00));
    check("t3b_sat", out_sat, 0);
    retire_main("t3b");

    // Backpressure with a second vector waiting
    set_z4(-5, 4660, 32767, 40000); set_cfg(1'b0, 1'b0, 8);
    send_main("t4a");
    set_z4(-300, -256, -40000, 32767); set_cfg(1'b1, 0, 8);
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check("t4_hold_valid", out_valid, 1);
      check("t4_hold_data", a_out_packed, exp4(8'h00, 8'h12, 8'h7f, 8'h7f));
      check("t4_hold_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("t4_rel_ready", in_ready, 1);
    check("t4_rel_valid", out_valid, 0);
    check("t4_rel_data_held", a_out_packed, exp4(8'h00, 8'h12, 8'h7f, 8'h7f));
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("t4_second_busy", busy, 1);
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    check("t4_second_latency", lat, 4);
    check("t4_second_data", a_out_packed, exp4(8'hfe, 8'hff, 8'h80, 8'h7f));
    check("t4_second_sat", out_sat, 1);
    retire_main("t4b");

    // Reset during beat 2
    set_z4(383, 384, 127, 128); set_cfg(1'b0, 1'b1, 8);
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("t5_out_valid", out_valid, 0);
    check("t5_a_out", a_out_packed, 0);
    check("t5_in_ready", in_ready, 1);
    check("t5_busy", busy, 0);
    check("t5_sat", out_sat, 0);
    set_z4(383, 384, 127, 128); set_cfg(1'b0, 1'b1, 8);
    send_main("t5b");
    check("t5b_data", a_out_packed, exp4(8'd1, 8'd2, 8'd0, 8'd1));
    retire_main("t5b");

    // Alternate lane counts against the reference model
    for (int i = 0; i < 4; i++) begin
      rand_vec(0, 1);
      rand_vec(1, 32);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
